key_debouncer: RTL and testbench

// - Four-channel debouncer for the raw keypad lines (active-low: 0 = key pressed, 1 = idle).
// - Sits directly upstream of the key-press detector and drives its four debounced inputs.
// - Each channel has a 2-FF synchronizer and a stability counter.
// - A debounced output changes only after the synchronized input has held the new level
//   for STABLE_CYCLES consecutive clocks.

---
 rtl/key_debouncer_if.sv | 34 +++
 rtl/key_debouncer.sv | 86 ++++++++
 tb/tb_key_debouncer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/key_debouncer_if.sv
// Keypad line bundle between the raw keypad lines and the key_debouncer.
// Optional edge-pulse signals exist only when KEY_DEBOUNCER_EDGE_OUT_EN is defined.
interface key_debouncer_if;
    logic       raw1_i;
    logic       raw2_i;
    logic       raw3_i;
    logic       raw4_i;
    logic       deb1_o;
    logic       deb2_o;
    logic       deb3_o;
    logic       deb4_o;
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
    logic [3:0] press_o;
    logic [3:0] release_o;

    modport master (
        output raw1_i, raw2_i, raw3_i, raw4_i,
        input  deb1_o, deb2_o, deb3_o, deb4_o, press_o, release_o
    );
    modport slave (
        input  raw1_i, raw2_i, raw3_i, raw4_i,
        output deb1_o, deb2_o, deb3_o, deb4_o, press_o, release_o
    );
`else
    modport master (
        output raw1_i, raw2_i, raw3_i, raw4_i,
        input  deb1_o, deb2_o, deb3_o, deb4_o
    );
    modport slave (
        input  raw1_i, raw2_i, raw3_i, raw4_i,
        output deb1_o, deb2_o, deb3_o, deb4_o
    );
`endif
endinterface

// File: rtl/key_debouncer.sv
// Four-channel active-low keypad debouncer: 2-FF synchronizer plus stability counter per line.
// Define KEY_DEBOUNCER_EDGE_OUT_EN to add registered one-cycle press_o/release_o pulses.
module key_debouncer #(
    parameter int unsigned STABLE_CYCLES = 100000,
    parameter int unsigned CNT_WIDTH     = 17
) (
    input  logic          clk,
    input  logic          rst_n,
    key_debouncer_if.slave kif
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 32'd1);

    generate
        if ((STABLE_CYCLES < 32'd1) || (64'(STABLE_CYCLES) > (64'd1 << CNT_WIDTH))) begin : g_bad_cfg
            $error("key_debouncer: STABLE_CYCLES must be in 1 .. 2**CNT_WIDTH");
        end
    endgenerate

    logic [3:0]           raw_s;
    logic [3:0]           sync0_q;
    logic [3:0]           sync_q;
    logic [3:0]           deb_q;
    logic [3:0]           deb_d;
    logic [CNT_WIDTH-1:0] cnt_q [4];
    logic [CNT_WIDTH-1:0] cnt_d [4];
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
    logic [3:0]           press_q;
    logic [3:0]           release_q;
`endif

    assign raw_s = {kif.raw4_i, kif.raw3_i, kif.raw2_i, kif.raw1_i};

    // Per-channel qualification: any agreement between sync and output restarts the count.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] == deb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                deb_d[i] = sync_q[i];
                cnt_d[i] = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
            end
        end
    end

    // State registers with synchronous active-low reset to the idle (released) level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync0_q <= 4'b1111;
            sync_q  <= 4'b1111;
            deb_q   <= 4'b1111;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
            press_q   <= 4'b0000;
            release_q <= 4'b0000;
`endif
        end else begin
            sync0_q <= raw_s;
            sync_q  <= sync0_q;
            deb_q   <= deb_d;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
            press_q   <= deb_q & ~deb_d;
            release_q <= ~deb_q & deb_d;
`endif
        end
    end

    assign kif.deb1_o = deb_q[0];
    assign kif.deb2_o = deb_q[1];
    assign kif.deb3_o = deb_q[2];
    assign kif.deb4_o = deb_q[3];
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
    assign kif.press_o   = press_q;
    assign kif.release_o = release_q;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: per-cycle scoreboard against a behavioural model
// plus directed latency checks for press, bounce, multi-key and mid-count reset.
module tb_key_debouncer;

    localparam int unsigned S  = 4;
    localparam int unsigned CW = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [3:0] raw_v;

    always #5 clk = ~clk;

    key_debouncer_if kif ();

    key_debouncer #(.STABLE_CYCLES(S), .CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kif   (kif)
    );

    typedef struct {
        logic [3:0] deb;
        logic [3:0] pr;
        logic [3:0] rl;
    } exp_t;

    exp_t exp_q [$];

    logic [3:0] m_s0, m_s1, m_deb, m_pr, m_rl;
    int         m_cnt [4];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [3:0] obs_deb();
        return {kif.deb4_o, kif.deb3_o, kif.deb2_o, kif.deb1_o};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive inputs, advance the model by one edge, push expectation, then compare after the edge.
    task automatic step();
        logic [3:0] prev;
        exp_t e;
        kif.raw1_i = raw_v[0];
        kif.raw2_i = raw_v[1];
        kif.raw3_i = raw_v[2];
        kif.raw4_i = raw_v[3];
        if (!rst_n) begin
            m_s0 = 4'b1111; m_s1 = 4'b1111; m_deb = 4'b1111;
            m_pr = 4'b0000; m_rl = 4'b0000;
            for (int c = 0; c < 4; c++) m_cnt[c] = 0;
        end else begin
            prev = m_deb;
            for (int c = 0; c < 4; c++) begin
                if (m_s1[c] == m_deb[c]) m_cnt[c] = 0;
                else if (m_cnt[c] < int'(S) - 1) m_cnt[c] = m_cnt[c] + 1;
                else begin
                    m_deb[c] = m_s1[c];
                    m_cnt[c] = 0;
                end
            end
            m_s1 = m_s0;
            m_s0 = raw_v;
            m_pr = prev & ~m_deb;
            m_rl = ~prev & m_deb;
        end
        e.deb = m_deb; e.pr = m_pr; e.rl = m_rl;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("sb_deb", 32'(obs_deb()), 32'(e.deb));
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
        check("sb_press", 32'(kif.press_o), 32'(e.pr));
        check("sb_release", 32'(kif.release_o), 32'(e.rl));
`endif
    endtask

    // Step until channel ch reaches lvl (bounded); n = edges taken, 40 on timeout.
    task automatic wait_deb(input int ch, input logic lvl, output int n);
        logic [3:0] d;
        n = 0;
        d = obs_deb();
        while (d[ch] !== lvl && n < 40) begin
            step();
            n++;
            d = obs_deb();
        end
    endtask

    initial begin
        int n;
        logic [3:0] d;
        logic b [7];
        b = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst_n = 1'b0;
        raw_v = 4'b0000;
        repeat (3) begin
            step();
            check("rst_deb", 32'(obs_deb()), 32'(4'b1111));
        end
        rst_n = 1'b1;
        raw_v = 4'b1111;
        step();
        check("rst_release_deb", 32'(obs_deb()), 32'(4'b1111));
        repeat (3) step();

        // clean press and release on channel 1
        raw_v[0] = 1'b0;
        wait_deb(0, 1'b0, n);
        check("press_lat", 32'(n), 32'd6);
        d = obs_deb();
        check("others_idle", 32'(d[3:1]), 32'(3'b111));
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
        check("press_o", 32'(kif.press_o), 32'(4'b0001));
`endif
        repeat (2) step();
        raw_v[0] = 1'b1;
        wait_deb(0, 1'b1, n);
        check("release_lat", 32'(n), 32'd6);
`ifdef KEY_DEBOUNCER_EDGE_OUT_EN
        check("release_o", 32'(kif.release_o), 32'(4'b0001));
`endif
        repeat (2) step();

        // bounce on channel 2
        n = 0;
        for (int i = 0; i < 7; i++) begin
            raw_v[1] = b[i];
            step();
            n++;
        end
        d = obs_deb();
        while (d[1] !== 1'b0 && n < 40) begin
            step();
            n++;
            d = obs_deb();
        end
        check("bounce_lat", 32'(n), 32'd9);
        raw_v[1] = 1'b1;
        wait_deb(1, 1'b1, n);
        repeat (2) step();

        // multi-key on channels 3 and 4
        raw_v[3:2] = 2'b00;
        wait_deb(2, 1'b0, n);
        check("multi_fall_lat", 32'(n), 32'd6);
        d = obs_deb();
        check("multi_fall_same", 32'(d[3]), 32'd0);
        repeat (2) step();
        raw_v[3:2] = 2'b11;
        wait_deb(2, 1'b1, n);
        check("multi_rise_lat", 32'(n), 32'd6);
        d = obs_deb();
        check("multi_rise_same", 32'(d[3]), 32'd1);
        repeat (2) step();

        // reset in the middle of a qualification
        raw_v[0] = 1'b0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        d = obs_deb();
        check("midrst_deb", 32'(d[0]), 32'd1);
        rst_n = 1'b1;
        wait_deb(0, 1'b0, n);
        check("midrst_lat", 32'(n), 32'd6);
        raw_v[0] = 1'b1;
        wait_deb(0, 1'b1, n);

        // random bouncing on all channels, checked by the scoreboard
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 4; c++) begin
                if ($urandom_range(0, 3) == 0) raw_v[c] = ~raw_v[c];
            end
            step();
        end
        raw_v = 4'b0101;
        repeat (8) step();
        check("random_settle", 32'(obs_deb()), 32'(4'b0101));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
